// File: rtl/pdq_pkg.sv
// pdq_pkg: shared frame-flag constants, FSM state encoding
// and flag helpers for the packet dequeue engine.
package pdq_pkg;

    localparam logic [1:0] FLG_MID    = 2'b00;
    localparam logic [1:0] FLG_HEAD   = 2'b01;
    localparam logic [1:0] FLG_TAIL   = 2'b10;
    localparam logic [1:0] FLG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_head(input logic [1:0] f);
        return (f == FLG_HEAD) || (f == FLG_SINGLE);
    endfunction

    function automatic logic is_tail(input logic [1:0] f);
        return (f == FLG_TAIL) || (f == FLG_SINGLE);
    endfunction

endpackage

// File: rtl/onehot8_enc.sv
// onehot8_enc: 8-bit one-hot to index encoder.
// Ports: oh in 8, idx out 3, invalid out 1 (zero or multi-hot).
module onehot8_enc (
    input  logic [7:0] oh,
    output logic [2:0] idx,
    output logic       invalid
);

    always_comb begin
        invalid = (oh == 8'd0) || ((oh & (oh - 8'd1)) != 8'd0);
        idx     = 3'd0;
        if (!invalid) begin
            unique case (1'b1)
                oh[0]: idx = 3'd0;
                oh[1]: idx = 3'd1;
                oh[2]: idx = 3'd2;
                oh[3]: idx = 3'd3;
                oh[4]: idx = 3'd4;
                oh[5]: idx = 3'd5;
                oh[6]: idx = 3'd6;
                oh[7]: idx = 3'd7;
            endcase
        end
    end

endmodule

// File: rtl/pkt_dequeue.sv
// pkt_dequeue: reads one packet from the granted queue FIFO into
// the UDO FIFO, then pulses outport_free to the scheduler.
// Ports: clk, rst (sync, active-high); in_pdq_selected one-hot
// grant; in_pdq_q_empty / in_pdq_q_data show-ahead queue heads;
// out_pdq_q_rd read ack; in_pdq_udo_alf stall; out_pdq_udo_data /
// out_pdq_udo_wr registered UDO write; out_pdq_outport_free done
// pulse; out_pdq_pkt_cnt wrapping, out_pdq_err_cnt saturating.
module pkt_dequeue
    import pdq_pkg::*;
#(
    parameter int DATA_W    = 134,
    parameter int NQ        = 8,
    parameter int MAX_WORDS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NQ-1:0]        in_pdq_selected,
    input  logic [NQ-1:0]        in_pdq_q_empty,
    input  logic [NQ*DATA_W-1:0] in_pdq_q_data,
    output logic [NQ-1:0]        out_pdq_q_rd,
    input  logic                 in_pdq_udo_alf,
    output logic [DATA_W-1:0]    out_pdq_udo_data,
    output logic                 out_pdq_udo_wr,
    output logic                 out_pdq_outport_free,
    output logic [31:0]          out_pdq_pkt_cnt,
    output logic [15:0]          out_pdq_err_cnt
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int PW = DATA_W - 2;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        idx;
    logic [2:0]        sel_idx;
    logic              sel_bad;
    logic              sel_ok;
    logic              in_pkt;
    logic [CW-1:0]     wcnt;
    logic [CW-1:0]     cnt_nxt;
    logic [DATA_W-1:0] q_word [NQ];
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] wr_word;
    logic [1:0]        flg;
    logic [1:0]        flg_out;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;
    logic              rd_ok;
    logic              accept;
    logic              discard;
    logic              dup_head;
    logic              abort;
    logic              last;

    onehot8_enc u_enc (
        .oh      (in_pdq_selected),
        .idx     (sel_idx),
        .invalid (sel_bad)
    );

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            q_word[i] = in_pdq_q_data[i*DATA_W +: DATA_W];
        end
    end

    assign word   = q_word[idx];
    assign flg    = word[DATA_W-1 -: 2];
    assign sel_ok = (state == S_IDLE) && !sel_bad;

    assign rd_ok = (state == S_READ)
                 && !in_pdq_q_empty[idx]
                 && !in_pdq_udo_alf;

    assign out_pdq_q_rd = rd_ok
        ? ({{(NQ-1){1'b0}}, 1'b1} << idx)
        : '0;

    // Until a head arrives, every word is junk and dropped.
    assign accept   = rd_ok && (in_pkt || is_head(flg));
    assign discard  = rd_ok && !accept;
    assign dup_head = accept && in_pkt && is_head(flg);
    assign cnt_nxt  = in_pkt ? wcnt + CW'(1) : CW'(1);
    assign abort    = accept && !is_tail(flg)
                    && (cnt_nxt == CW'(MAX_WORDS));
    assign last     = accept && (is_tail(flg) || abort);

    // A stray head inside a packet is demoted so the UDO
    // stream stays well formed; a forced end becomes a tail.
    always_comb begin
        flg_out = flg;
        if (abort || (dup_head && is_tail(flg))) begin
            flg_out = FLG_TAIL;
        end else if (dup_head) begin
            flg_out = FLG_MID;
        end
    end

    assign wr_word = {flg_out, word[PW-1:0]};

    assign err_inc =
        {1'b0, (state == S_IDLE) && sel_bad
               && (|in_pdq_selected)}
      + {1'b0, discard}
      + {1'b0, dup_head}
      + {1'b0, abort};

    assign err_sum = {1'b0, out_pdq_err_cnt} + {15'd0, err_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        out_pdq_outport_free = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!sel_bad) state_nxt = S_READ;
            end
            S_READ: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_pdq_outport_free = 1'b1;
                state_nxt            = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            in_pkt           <= 1'b0;
            wcnt             <= '0;
            out_pdq_udo_wr   <= 1'b0;
            out_pdq_udo_data <= '0;
            out_pdq_pkt_cnt  <= '0;
            out_pdq_err_cnt  <= '0;
        end else begin
            out_pdq_udo_wr <= accept;
            if (accept) begin
                out_pdq_udo_data <= wr_word;
                in_pkt           <= 1'b1;
                wcnt             <= cnt_nxt;
            end
            if (sel_ok) begin
                idx    <= sel_idx;
                in_pkt <= 1'b0;
                wcnt   <= '0;
            end
            if (state == S_DONE) begin
                out_pdq_pkt_cnt <= out_pdq_pkt_cnt + 32'd1;
            end
            out_pdq_err_cnt <= err_sum[16] ? 16'hFFFF
                                           : err_sum[15:0];
        end
    end

endmodule

// File: doc/pkt_dequeue.md
# pkt_dequeue

Per-port packet dequeue engine on the transmit side of the TSN NIC datapath. The egress priority scheduler grants one of eight queues with a one-hot select. This block accepts the grant and reads exactly one packet from the granted queue FIFO. It writes that packet into the output FIFO (UDO), then returns a one-cycle port-free pulse to the scheduler so the next grant can be issued.

## Interface
- DATA_W, 134: word width; bits [DATA_W-1:DATA_W-2] are frame flags, the remaining bits are byte-valid + payload, passed through untouched.
- NQ, 8: number of queues; fixed at 8 for this release.
- MAX_WORDS, 128: longest legal packet in words; the abort threshold.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_pdq_selected  in  8  one-hot queue grant from the scheduler.
- in_pdq_q_empty  in  8  per-queue FIFO empty; queue FIFOs are show-ahead.
- in_pdq_q_data  in  8*DATA_W  per-queue FIFO head word; queue i occupies bits [i*DATA_W +: DATA_W].
- out_pdq_q_rd  out  8  per-queue read acknowledge, combinational.
- in_pdq_udo_alf  in  1  UDO FIFO almost-full; stalls reads.
- out_pdq_udo_data  out  DATA_W  word to UDO.
- out_pdq_udo_wr  out  1  UDO write strobe.
- out_pdq_outport_free  out  1  one-cycle pulse: packet finished.
- out_pdq_pkt_cnt  out  32  packets completed; wraps.
- out_pdq_err_cnt  out  16  protocol errors; saturates at 16'hFFFF.

## Operation
- Frame flags: 2'b01 head, 2'b00 middle, 2'b10 tail, 2'b11 single-word packet (head and tail).
- States: IDLE, READ, DONE.
- IDLE
  - A select with exactly one bit set latches queue index `idx` and moves to READ; the word counter clears.
  - All-zero select: ignored, stays in IDLE.
  - Select with more than one bit set: ignored, err_cnt +1, stays in IDLE.
- READ
  - out_pdq_q_rd[idx] = !in_pdq_q_empty[idx] && !in_pdq_udo_alf; all other rd bits are 0.
  - Each acknowledged word is registered to out_pdq_udo_data with out_pdq_udo_wr=1 on the next cycle; the word counter increments.
  - First word not flagged head or single: read and discarded (no UDO write), err_cnt +1, still waiting for a head.
  - Head seen while already inside a packet: written to UDO, err_cnt +1, treated as a middle word.
  - Tail or single word acknowledged: move to DONE.
  - Word counter reaches MAX_WORDS with no tail: that word is written with flags forced to 2'b10, err_cnt +1, move to DONE.
  - Queue empty or alf asserted: stall indefinitely with no rd and no wr; no timeout.
- DONE: out_pdq_outport_free=1 for exactly one cycle, pkt_cnt +1, return to IDLE.
- Selects arriving in READ or DONE are ignored and are not errors.
- Reset: state IDLE, all outputs 0, counters 0. No free pulse is generated for a packet aborted by reset.

## Timing
- Select sampled at cycle T → READ at T+1 → first rd possible at T+1 → first UDO write at T+2.
- Tail acknowledged at cycle k → tail written (wr=1) at k+1 (state DONE) → outport_free=1 at k+1 → IDLE at k+2 → next select accepted at k+2.
- Single-word packet with no stalls: select at T, wr at T+2, free pulse at T+2.
- Throughput: one word per cycle while the queue is non-empty and alf is low.
- udo_data and udo_wr are registered; q_rd is combinational from state, idx, empty and alf.

## Structure
- Shared package pdq_pkg holds the frame-flag constants (FLG_HEAD, FLG_MID, FLG_TAIL, FLG_SINGLE) and the state encoding.
- Sub-module onehot8_enc: one-hot-to-index encoder with an invalid flag (zero bits or more than one bit set).
- Counters and the data mux stay in the top module.

## Test plan
- Select 8'b0000_0100; queue 2 holds a 4-word packet (head, mid, mid, tail) → rd[2] at T+1..T+4, UDO writes T+2..T+5 in order, free pulse at T+5, pkt_cnt=1.
- Select 8'b1000_0000; queue 7 holds one single-flag word → one UDO write at T+2, free at T+2, pkt_cnt=1.
- Select 8'b0001_0001 → no rd, no wr, err_cnt=1, state stays IDLE.
- 6-word packet with alf high for 3 cycles after word 2 → no rd/wr during the stall, all 6 words delivered in order, a single free pulse.
- Queue holds a 130-word packet with no tail → word 128 written with flags 2'b10, err_cnt=1, free pulse; the remaining 2 words stay queued.
- rst asserted during word 3 of 5 → next cycle: all outputs 0, state IDLE, no free pulse; a new select starts cleanly.
